// File: rtl/mips_pkg.sv
// Shared MIPS decode definitions.
// Opcodes, functs and the decoded-instruction bundle.
package mips_pkg;

    localparam int ALU_CTRL_W = 12;

    typedef logic [ALU_CTRL_W-1:0] alu_ctrl_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    typedef enum logic [2:0] {
        SRC2_ZERO,
        SRC2_RT,
        SRC2_SEXT,
        SRC2_ZEXT,
        SRC2_LUI
    } src2_sel_e;

    typedef struct packed {
        alu_ctrl_t  control;
        src2_sel_e  src2_sel;
        logic [4:0] dest;
        logic       reads_rs;
        logic       reads_rt;
        logic       reg_write;
        logic       illegal;
    } dec_t;

    function automatic logic [31:0] onehot(input logic [4:0] a);
        return 32'h1 << a;
    endfunction

endpackage

// File: rtl/decode_stage_if.sv
// Instruction-in / ALU-operands-out handshake bundle.
// master drives instructions and consumes operands.
interface decode_stage_if #(
    parameter int XLEN = 32
);
    import mips_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    alu_ctrl_t       out_control;
    logic [XLEN-1:0] out_src1;
    logic [XLEN-1:0] out_src2;
    logic [4:0]      out_dest;
    logic            out_reg_write;
    logic            out_illegal;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_control,
        input  out_src1, out_src2, out_dest,
        input  out_reg_write, out_illegal
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_control,
        output out_src1, out_src2, out_dest,
        output out_reg_write, out_illegal
    );

endinterface

// File: rtl/decode_stage_reg_file.sv
// 2-read / 1-write register file, r0 hardwired to zero.
// Reads see a same-cycle write through a bypass.
module decode_stage_reg_file #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    localparam int AW = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [AW-1:0]   raddr1,
    output logic [XLEN-1:0] rdata1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata2,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata
);

    logic [XLEN-1:0] mem [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 :
                    (we && waddr == raddr1) ? wdata :
                    mem[raddr1];

    assign rdata2 = (raddr2 == '0) ? '0 :
                    (we && waddr == raddr2) ? wdata :
                    mem[raddr2];

endmodule

// File: rtl/decode_stage.sv
// MIPS decode stage: regfile read, operand build, RAW scoreboard.
// One-entry output register with valid/ready handshake.
module decode_stage
    import mips_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst,
    decode_stage_if.slave   io,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            flush
);

    logic [5:0]      op;
    logic [5:0]      fn;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [15:0]     imm;
    logic            fn_ok;
    dec_t            dec;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] src1;
    logic [XLEN-1:0] src2;
    logic [31:0]     pending;
    logic [31:0]     eff_pending;
    logic [31:0]     set_mask;
    logic            stall;
    logic            accept;

    logic            valid_q;
    alu_ctrl_t       ctrl_q;
    logic [XLEN-1:0] src1_q;
    logic [XLEN-1:0] src2_q;
    logic [4:0]      dest_q;
    logic            rw_q;
    logic            ill_q;

    assign op  = io.in_instr[31:26];
    assign rs  = io.in_instr[25:21];
    assign rt  = io.in_instr[20:16];
    assign rd  = io.in_instr[15:11];
    assign imm = io.in_instr[15:0];
    assign fn  = io.in_instr[5:0];

    assign fn_ok = fn inside {FN_ADD, FN_ADDU, FN_SUB,
                              FN_AND, FN_OR, FN_SLT};

    always_comb begin
        dec = '0;
        unique case (1'b1)
            (op == OP_RTYPE) && fn_ok: begin
                dec.control  = {6'b0, fn};
                dec.src2_sel = SRC2_RT;
                dec.dest     = rd;
                dec.reads_rs = 1'b1;
                dec.reads_rt = 1'b1;
            end
            op == OP_ADDI,
            op == OP_ADDIU,
            op == OP_SLTI: begin
                dec.control  = {op, 6'b0};
                dec.src2_sel = SRC2_SEXT;
                dec.dest     = rt;
                dec.reads_rs = 1'b1;
            end
            op == OP_ANDI,
            op == OP_ORI: begin
                dec.control  = {op, 6'b0};
                dec.src2_sel = SRC2_ZEXT;
                dec.dest     = rt;
                dec.reads_rs = 1'b1;
            end
            op == OP_LUI: begin
                dec.control  = {op, 6'b0};
                dec.src2_sel = SRC2_LUI;
                dec.dest     = rt;
            end
            default: dec.illegal = 1'b1;
        endcase
        dec.reg_write = !dec.illegal && (dec.dest != 5'd0);
    end

    decode_stage_reg_file #(
        .XLEN(XLEN),
        .NREG(NREG)
    ) u_rf (
        .clk    (clk),
        .rst    (rst),
        .raddr1 (rs),
        .rdata1 (rs_val),
        .raddr2 (rt),
        .rdata2 (rt_val),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data)
    );

    assign src1 = dec.reads_rs ? rs_val : '0;

    always_comb begin
        src2 = '0;
        unique case (dec.src2_sel)
            SRC2_RT:   src2 = rt_val;
            SRC2_SEXT: src2 = XLEN'({{16{imm[15]}}, imm});
            SRC2_ZEXT: src2 = XLEN'(imm);
            SRC2_LUI:  src2 = XLEN'({imm, 16'h0});
            default:   src2 = '0;
        endcase
    end

    // A retiring writeback unblocks its consumer in the same cycle.
    assign eff_pending = pending &
                         ~(wb_en ? onehot(wb_addr) : 32'h0);

    assign stall = io.in_valid &&
                   ((dec.reads_rs && eff_pending[rs]) ||
                    (dec.reads_rt && eff_pending[rt]));

    assign io.in_ready = !stall &&
                         (!valid_q || io.out_ready) &&
                         !flush;

    assign accept = io.in_valid && io.in_ready;

    assign set_mask = (accept && dec.reg_write) ?
                      onehot(dec.dest) : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
            valid_q <= 1'b0;
            ctrl_q  <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dest_q  <= '0;
            rw_q    <= 1'b0;
            ill_q   <= 1'b0;
        end else if (flush) begin
            pending <= '0;
            valid_q <= 1'b0;
        end else begin
            pending <= (eff_pending | set_mask) & ~32'h1;
            if (accept) begin
                valid_q <= 1'b1;
                ctrl_q  <= dec.control;
                src1_q  <= src1;
                src2_q  <= src2;
                dest_q  <= dec.illegal ? 5'd0 : dec.dest;
                rw_q    <= dec.reg_write;
                ill_q   <= dec.illegal;
            end else if (io.out_ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign io.out_valid     = valid_q;
    assign io.out_control   = ctrl_q;
    assign io.out_src1      = src1_q;
    assign io.out_src2      = src2_q;
    assign io.out_dest      = dest_q;
    assign io.out_reg_write = rw_q;
    assign io.out_illegal   = ill_q;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Instruction-decode stage directly upstream of the ALU.
- Takes a 32-bit MIPS instruction, reads operands from an internal 32x32 register file, and builds the ALU inputs: 12-bit control {opcode,funct}, src1 and src2.
- Holds the result in a one-entry output register with a valid/ready handshake.
- A pending-write scoreboard stalls read-after-write hazards until writeback retires the producer.

Parameters:
- XLEN, 32, datapath width.
- NREG, 32, register count; index width is $clog2(NREG).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts instruction this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  ALU inputs valid.
- out_ready  in  1  ALU stage consumes this cycle.
- out_control  out  12  ALU control {opcode[5:0],funct[5:0]}.
- out_src1  out  XLEN  operand 1 (rs value).
- out_src2  out  XLEN  operand 2 (rt value or extended immediate).
- out_dest  out  5  destination register.
- out_reg_write  out  1  instruction writes out_dest.
- out_illegal  out  1  unsupported opcode/funct.
- wb_en  in  1  writeback strobe.
- wb_addr  in  5  writeback register.
- wb_data  in  XLEN  writeback data.
- flush  in  1  pipeline-wide flush.

Behaviour:
- Reset (async, rst=1): all out_* = 0; scoreboard = 0; register file contents = 0.
- in_ready = !stall && (!out_valid || out_ready) && !flush.
- Register file: combinational read, write on clk rising edge when wb_en && wb_addr!=0.
  - r0 always reads 0.
  - Same-cycle bypass: if wb_en and wb_addr==rs (or rt) and the address is !=0, the read returns wb_data.
- Decode (combinational from in_instr):
  - opcode 0 (R-type), funct in {add 100000, addu 100001, sub 100010, and 100100, or 100101, slt 101010}: control={000000,funct}; src2=rt value; dest=rd; reads rs and rt.
  - addi 001000, addiu 001001, slti 001010: control={opcode,000000}; src2=sign-extended imm16; dest=rt; reads rs only.
  - andi 001100, ori 001101: same as above but src2 is zero-extended imm16.
  - lui 001111: src2={imm16,16'h0}; src1=0; dest=rt; reads nothing.
  - Any other encoding: illegal=1, control=0, reg_write=0, src1=src2=0, dest=0.
  - reg_write = legal && dest!=0.
- Scoreboard: pending[31:0].
  - Effective pending = pending & ~(wb_en ? onehot(wb_addr) : 0).
  - stall = in_valid && ((reads rs && eff_pending[rs]) || (reads rt && eff_pending[rt])).
  - pending[0] is never set.
- Accept (in_valid && in_ready), at the clk edge:
  - Load the output register with the decoded fields; out_valid <= 1.
  - If reg_write: set pending[dest].
  - On the same register, a set wins over a same-cycle wb clear.
- Consume: out_valid && out_ready && no accept -> out_valid <= 0; other outputs hold their values.
- Accept and consume in the same cycle: back-to-back throughput of 1 instr/cycle; decode latency 1 cycle.
- Output stability: when out_valid && !out_ready, all out_* hold.
- Flush (sync, highest priority):
  - Next edge: out_valid <= 0, pending <= 0, no accept.
  - A wb_en in the same cycle still writes the register file.
- Illegal instructions are passed downstream with out_illegal=1; they do not touch the scoreboard.

Decomposition:
- mips_pkg: opcode/funct localparams, ALU_CTRL_W=12, typedef alu_ctrl_t, and a decoded-instruction struct {control, src2_sel, dest, reads_rs, reads_rt, reg_write, illegal}.
- Sub-module reg_file: 2 read ports, 1 write port, r0 hardwired to 0, with bypass.
- Decode logic and scoreboard stay in decode_stage.

Test Plan:
- Reset, then wb r1=5, r2=7, then issue `add r3,r1,r2` (0x00221820) -> one cycle later out_valid=1, control=12'h020, src1=5, src2=7, dest=3, reg_write=1.
- `addi r4,r1,-1` (0x2024FFFF) with r1=5 -> control=12'h200, src1=5, src2=32'hFFFFFFFF, dest=4; `ori r4,r1,0xFFFF` -> src2=32'h0000FFFF.
- Issue `addi r5,r0,1`, then `add r6,r5,r5` -> second stalls (in_ready=0) until wb r5; in the wb cycle it is accepted, and src1=src2 equals wb_data via bypass.
- Hold out_ready=0 for 3 cycles with in_valid=1 -> outputs stable, in_ready=0, no instruction lost; release -> 1 instr/cycle.
- Flush while out_valid=1 and pending[5]=1 -> next cycle out_valid=0, pending=0, a dependent instruction on r5 accepted without stall.
- Opcode 6'b111111 -> out_illegal=1, control=0, reg_write=0; writes to r0 via wb are ignored (r0 reads 0); async rst mid-stream clears out_valid without waiting for an edge.
